alu_arbiter: RTL
================

# alu_arbiter

Two-requester controller that shares the single-cycle 32-bit ALU between independent clients (e.g. main datapath and an address/branch helper). It accepts one operation at a time via a valid/ready handshake and arbitrates round-robin when both clients request. It drives the registered operands and control code into the ALU, captures the result and zero flag, and returns them to the issuing requester through a response handshake.

## Interface
- `WIDTH`, 32, operand/result width
- `CTRL_W`, 4, ALU control code width. Codes: AND 0000, OR 0001, ADD 0010, SUB 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req0_valid` / `req1_valid`  in  1  requester i presents an operation
- `req0_ready` / `req1_ready`  out  1  arbiter accepts requester i this cycle
- `req0_op1`, `req0_op2` / `req1_op1`, `req1_op2`  in  WIDTH  operands
- `req0_ctrl` / `req1_ctrl`  in  CTRL_W  ALU control code
- `rsp0_valid` / `rsp1_valid`  out  1  result available for requester i
- `rsp0_ready` / `rsp1_ready`  in  1  requester i consumes result
- `rsp_result`  out  WIDTH  captured ALU result (shared; qualified by rspN_valid)
- `rsp_zero`  out  1  captured ALU zero flag
- `alu_op1`, `alu_op2`  out  WIDTH  to ALU operands, always driven from registers
- `alu_control`  out  CTRL_W  to ALU control, registered
- `alu_result`  in  WIDTH  from ALU
- `alu_zero`  in  1  from ALU
- `busy`  out  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational from `req*_valid` and a 1-bit `last` pointer.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not equal to `last` is granted.
  - `reqN_ready` = (state==IDLE) && grant==N. At most one ready is high per cycle; ready is low for a requester that is not valid.
  - On handshake: latch op1/op2/ctrl into `alu_op1`/`alu_op2`/`alu_control`, latch owner, go to EXEC.
- EXEC (exactly 1 cycle): capture `alu_result` into `rsp_result` and `alu_zero` into `rsp_zero`, go to RESP.
- RESP:
  - `rspN_valid` is high only for owner N.
  - Hold the result until `rspN_ready`.
  - On handshake: `last` <= owner, go to IDLE.
- Control codes 1010–1111 are passed through unchanged. The ALU returns 0, so the response is result 0, zero 1. No error is flagged.
- `alu_*` outputs hold their last values outside EXEC (no toggling).
- One outstanding operation. New requests are ignored (ready low) in EXEC and RESP.
- Requester inputs need only be stable in the handshake cycle.
- Fairness: a continuously valid requester is granted within 2 grants.

## Timing
- Reset (async assert, sync-released use):
  - state IDLE, `last`=1 (requester 0 wins the first tie).
  - `alu_op1`/`alu_op2`=0, `alu_control`=0000.
  - `rsp_result`=0, `rsp_zero`=0, all `rspN_valid`=0, `busy`=0.
  - `reqN_ready` evaluates from IDLE immediately after reset.
- Latency:
  - Request handshake at edge N.
  - ALU inputs are valid during cycle N+1 (EXEC).
  - `rspN_valid` rises after edge N+2.
- Throughput with `rsp_ready` held high: 1 operation per 3 cycles. A request valid in the cycle after the response handshake is accepted that cycle.
- `rsp_ready` low stalls in RESP indefinitely; the result stays stable.
- Reset mid-operation (EXEC or RESP): the transaction is dropped, no response is issued, and the pointer returns to 1.
- `reqN_valid` deasserted without a handshake is legal; nothing is latched.

## Test plan
- Single request: req0 ADD op1=5, op2=7, rsp0_ready=1 -> `rsp0_valid` 2 cycles after handshake, result=12, zero=0; `rsp1_valid` stays 0.
- Tie and fairness: both valid continuously after reset (req0 SUB 9,9; req1 SLTU 1,2) -> grant order 0,1,0,1. Req0 gets result 0, zero=1. Req1 gets result 1.
- Backpressure: req1 SRA op1=0x80000000, op2=4, rsp1_ready low 5 cycles -> `rsp1_valid` and result 0xF8000000 held stable. `req0_ready` and `req1_ready` both 0 throughout. Accepted after ready.
- Invalid code: req0 ctrl=1111 -> result 0, zero 1, normal 3-cycle turnaround.
- Reset in RESP: assert `rst_n`=0 while `rsp0_valid`=1 -> all outputs at reset values immediately. No response after release. The next tie is granted to requester 0.
- Back-to-back throughput: req0 issues 4 ops (SLL 1,31 -> 0x80000000; SLT -1,0 -> 1; OR 0xF0,0x0F -> 0xFF; XOR 3,3 -> 0/zero) with rsp0_ready=1 -> 4 responses in 12 cycles.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: lets two independent requesters share one single-cycle ALU.
// Only one operation is in flight at a time. When both requesters ask in the
// same cycle, the grant alternates round-robin. The operands and control code
// are registered toward the ALU. The ALU result and zero flag are captured and
// returned to the requester that issued the operation.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   reqN_valid/ready              request handshake for requester N (0/1)
//   reqN_op1/op2/ctrl             operands and ALU control code for requester N
//   rspN_valid/ready              response handshake for requester N
//   rsp_result, rsp_zero          captured ALU result/zero (shared, qualified by rspN_valid)
//   alu_op1/op2/control           registered drive into the ALU
//   alu_result, alu_zero          combinational return from the ALU
//   busy                          high whenever an operation is in flight
module alu_arbiter #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned CTRL_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [WIDTH-1:0]  req0_op1,
   input  logic [WIDTH-1:0]  req0_op2,
   input  logic [CTRL_W-1:0] req0_ctrl,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [WIDTH-1:0]  req1_op1,
   input  logic [WIDTH-1:0]  req1_op2,
   input  logic [CTRL_W-1:0] req1_ctrl,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [WIDTH-1:0]  rsp_result,
   output logic              rsp_zero,
   output logic [WIDTH-1:0]  alu_op1,
   output logic [WIDTH-1:0]  alu_op2,
   output logic [CTRL_W-1:0] alu_control,
   input  logic [WIDTH-1:0]  alu_result,
   input  logic              alu_zero,
   output logic              busy
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

   state_t state_q, state_d;
   logic   last_q;   // requester granted most recently; the other one wins a tie
   logic   owner_q;  // requester that owns the in-flight operation
   logic   grant0, grant1;
   logic   req_fire, rsp_fire;

   // Round-robin grant: a lone requester always wins; on a tie, not-last wins.
   always_comb begin
      grant0 = req0_valid && (!req1_valid || last_q);
      grant1 = req1_valid && (!req0_valid || !last_q);
   end

   always_comb begin
      req0_ready = (state_q == StIdle) && grant0;
      req1_ready = (state_q == StIdle) && grant1;
      req_fire   = req0_ready || req1_ready;
      rsp0_valid = (state_q == StResp) && !owner_q;
      rsp1_valid = (state_q == StResp) && owner_q;
      rsp_fire   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
      busy       = (state_q != StIdle);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (req_fire) state_d = StExec;
         StExec:  state_d = StResp;
         StResp:  if (rsp_fire) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers: the ALU drive only changes on a request handshake, so
   // it holds steady outside of the operation it belongs to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q      <= 1'b1;
         owner_q     <= 1'b0;
         alu_op1     <= '0;
         alu_op2     <= '0;
         alu_control <= '0;
         rsp_result  <= '0;
         rsp_zero    <= 1'b0;
      end else begin
         if (req_fire) begin
            owner_q     <= req1_ready;
            alu_op1     <= req1_ready ? req1_op1  : req0_op1;
            alu_op2     <= req1_ready ? req1_op2  : req0_op2;
            alu_control <= req1_ready ? req1_ctrl : req0_ctrl;
         end
         if (state_q == StExec) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
         end
         if (rsp_fire) begin
            last_q <= owner_q;
         end
      end
   end

endmodule
